// File: rtl/sisc_loader_pkg.sv
// Shared types and constants for the SISC boot-time program loader.
package sisc_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int unsigned MAX_WORDS_DEF = 1024;

    typedef enum logic [2:0] {
        ST_SYNC  = 3'd0,
        ST_LEN_H = 3'd1,
        ST_LEN_L = 3'd2,
        ST_DATA  = 3'd3,
        ST_CSUM  = 3'd4,
        ST_RUN   = 3'd5,
        ST_ERR   = 3'd6
    } ld_state_t;

endpackage

// File: rtl/ld_word_pack.sv
// Packs accepted payload bytes MSB-first into 32-bit words.
// The completed word and its strobe are combinational so the loader can register the write on the same edge.
module ld_word_pack (
    input  logic        clk,
    input  logic        rst_f,
    input  logic        clear,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] word_c,
    output logic        last_c
);

    logic [1:0]  cnt_q;
    logic [23:0] asm_q;

    // Only the lower three bytes need storing; the fourth arrives with the strobe.
    assign word_c = {asm_q, data};
    assign last_c = en && (cnt_q == 2'd3);

    always_ff @(posedge clk) begin
        if (rst_f || clear) begin
            cnt_q <= 2'd0;
            asm_q <= 24'd0;
        end else if (en) begin
            cnt_q <= cnt_q + 2'd1;
            asm_q <= word_c[23:0];
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Boot loader: framed byte stream -> instruction memory words, core held in reset
// until a complete, checksum-verified program has been written.
module prog_loader
    import sisc_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned MAX_WORDS = MAX_WORDS_DEF
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              core_rst_f,
    output logic              busy,
    output logic              done,
    output logic              err
);

    ld_state_t         state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [ADDR_W-1:0] widx_q, widx_d;
    logic [7:0]        csum_q, csum_d;

    logic        xfer_c;
    logic        pack_en_c;
    logic        pack_clr_c;
    logic [31:0] word_c;
    logic        last_c;

    logic ready_d, busy_d, done_d, err_d, core_rst_d;

    assign xfer_c     = in_valid && in_ready;
    assign pack_en_c  = xfer_c && (state_q == ST_DATA);
    assign pack_clr_c = (state_q != ST_DATA);

    ld_word_pack u_pack (
        .clk    (clk),
        .rst_f  (rst_f),
        .clear  (pack_clr_c),
        .en     (pack_en_c),
        .data   (in_data),
        .word_c (word_c),
        .last_c (last_c)
    );

    // Next-state, length/index/checksum and registered-output intent.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        widx_d     = widx_q;
        csum_d     = csum_q;
        ready_d    = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        core_rst_d = 1'b0;

        case (state_q)
            ST_SYNC: begin
                if (xfer_c && (in_data == SYNC_BYTE)) state_d = ST_LEN_H;
            end
            ST_LEN_H: begin
                if (xfer_c) begin
                    len_d   = {in_data, 8'h00};
                    state_d = ST_LEN_L;
                end
            end
            ST_LEN_L: begin
                if (xfer_c) begin
                    len_d  = {len_q[15:8], in_data};
                    widx_d = '0;
                    csum_d = 8'h00;
                    if ((len_d == 16'd0) || (32'(len_d) > 32'(MAX_WORDS)))
                        state_d = ST_ERR;
                    else
                        state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (xfer_c) begin
                    csum_d = csum_q ^ in_data;
                    if (last_c) begin
                        widx_d = widx_q + ADDR_W'(1);
                        if ((32'(widx_q) + 32'd1) == 32'(len_q)) state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (xfer_c) state_d = (in_data == csum_q) ? ST_RUN : ST_ERR;
            end
            default: ;
        endcase

        ready_d    = (state_d != ST_RUN) && (state_d != ST_ERR);
        busy_d     = ready_d && (state_d != ST_SYNC);
        done_d     = (state_d == ST_RUN);
        core_rst_d = (state_d == ST_RUN);
        err_d      = (state_d == ST_ERR);
    end

    always_ff @(posedge clk) begin
        if (rst_f) begin
            state_q    <= ST_SYNC;
            len_q      <= 16'd0;
            widx_q     <= '0;
            csum_q     <= 8'h00;
            in_ready   <= 1'b0;
            im_we      <= 1'b0;
            im_addr    <= '0;
            im_wdata   <= 32'd0;
            core_rst_f <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            widx_q     <= widx_d;
            csum_q     <= csum_d;
            in_ready   <= ready_d;
            im_we      <= last_c;
            if (last_c) begin
                im_addr  <= widx_q;
                im_wdata <= word_c;
            end
            core_rst_f <= core_rst_d;
            busy       <= busy_d;
            done       <= done_d;
            err        <= err_d;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frames with hand-computed words and checksums.
module tb_prog_loader;

    logic        clk;
    logic        rst_f;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        im_we;
    logic [15:0] im_addr;
    logic [31:0] im_wdata;
    logic        core_rst_f;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] wa[$];
    logic [31:0] wd[$];

    prog_loader dut (
        .clk        (clk),
        .rst_f      (rst_f),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .im_we      (im_we),
        .im_addr    (im_addr),
        .im_wdata   (im_wdata),
        .core_rst_f (core_rst_f),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write log sampled mid-cycle.
    always @(negedge clk) begin
        if (im_we) begin
            wa.push_back(im_addr);
            wd.push_back(im_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_data  = 8'h00;
        rst_f    = 1'b1;
        tick();
        tick();
        rst_f = 1'b0;
        wa.delete();
        wd.delete();
        tick();
    endtask

    task automatic send(input logic [7:0] b, input bit gap);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        if (gap) begin
            in_valid = 1'b0;
            in_data  = 8'hXX;
            tick();
        end
    endtask

    task automatic send_frame(input logic [7:0] f[$], input bit gap);
        foreach (f[i]) send(f[i], gap);
        in_valid = 1'b0;
    endtask

    task automatic check_writes(input string tag, input int n,
                                input logic [31:0] d0, input logic [31:0] d1);
        check({tag, "_nwr"}, 32'(wa.size()), 32'(n));
        if (wa.size() > 0) begin
            check({tag, "_a0"}, 32'(wa[0]), 32'd0);
            check({tag, "_d0"}, wd[0], d0);
        end
        if (wa.size() > 1 && n > 1) begin
            check({tag, "_a1"}, 32'(wa[1]), 32'd1);
            check({tag, "_d1"}, wd[1], d1);
        end
    endtask

    logic [7:0] frame1[$];
    logic [7:0] frame_bad[$];
    logic [7:0] frame_g[$];
    logic [7:0] frame_dead[$];

    initial begin
        frame1     = '{8'hA5, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
                       8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
        frame_bad  = '{8'hA5, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
                       8'h55, 8'h66, 8'h77, 8'h88, 8'h00};
        frame_g    = '{8'h00, 8'hFF, 8'h3C, 8'hA5, 8'h00, 8'h01,
                       8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
        frame_dead = '{8'hA5, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};

        // Reset values while rst_f is held.
        in_valid = 1'b0;
        in_data  = 8'h00;
        rst_f    = 1'b1;
        tick();
        tick();
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_we", 32'(im_we), 32'd0);
        check("rst_addr", 32'(im_addr), 32'd0);
        check("rst_wdata", im_wdata, 32'd0);
        check("rst_core", 32'(core_rst_f), 32'd0);
        check("rst_flags", {29'd0, busy, done, err}, 32'd0);
        rst_f = 1'b0;
        tick();
        check("ready_after_rst", 32'(in_ready), 32'd1);

        // Scenario 1: back-to-back frame with per-byte timing checks.
        wa.delete();
        wd.delete();
        foreach (frame1[i]) begin
            send(frame1[i], 1'b0);
            if (i == 0) check("s1_busy", 32'(busy), 32'd1);
            if (i == 6) begin
                check("s1_we_lat", 32'(im_we), 32'd1);
                check("s1_we_addr", 32'(im_addr), 32'd0);
                check("s1_we_data", im_wdata, 32'h11223344);
            end
            if (i == 7) check("s1_we_pulse", 32'(im_we), 32'd0);
            if (i == 10) check("s1_done_early", 32'(done), 32'd0);
            if (i == 11) begin
                check("s1_done", 32'(done), 32'd1);
                check("s1_core", 32'(core_rst_f), 32'd1);
            end
        end
        in_valid = 1'b0;
        tick();
        check_writes("s1", 2, 32'h11223344, 32'h55667788);
        check("s1_ready", 32'(in_ready), 32'd0);
        check("s1_err", 32'(err), 32'd0);
        check("s1_busy_end", 32'(busy), 32'd0);

        // Scenario 2: bad checksum.
        do_reset();
        send_frame(frame_bad, 1'b0);
        tick();
        check("s2_err", 32'(err), 32'd1);
        check("s2_core", 32'(core_rst_f), 32'd0);
        check("s2_done", 32'(done), 32'd0);
        check("s2_ready", 32'(in_ready), 32'd0);
        check_writes("s2", 2, 32'h11223344, 32'h55667788);

        // Scenario 3: leading garbage.
        do_reset();
        send_frame(frame_g, 1'b0);
        tick();
        check_writes("s3", 1, 32'hDEADBEEF, 32'h0);
        check("s3_done", 32'(done), 32'd1);
        check("s3_err", 32'(err), 32'd0);

        // Scenario 4a: zero length.
        do_reset();
        send(8'hA5, 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        in_valid = 1'b0;
        check("s4a_err", 32'(err), 32'd1);
        check("s4a_ready", 32'(in_ready), 32'd0);
        send(8'h12, 1'b0);
        in_valid = 1'b0;
        tick();
        check("s4a_nwr", 32'(wa.size()), 32'd0);

        // Scenario 4b: MAX_WORDS+1, then a full-length limit check.
        do_reset();
        send(8'hA5, 1'b0);
        send(8'h04, 1'b0);
        send(8'h01, 1'b0);
        in_valid = 1'b0;
        check("s4b_err", 32'(err), 32'd1);
        tick();
        check("s4b_nwr", 32'(wa.size()), 32'd0);

        do_reset();
        send(8'hA5, 1'b0);
        send(8'h04, 1'b0);
        send(8'h00, 1'b0);
        in_valid = 1'b0;
        check("s4c_max_ok", {30'd0, busy, err}, 32'd2);

        // Scenario 5: reset mid-frame, colliding with a byte; then a clean load.
        do_reset();
        for (int i = 0; i < 9; i++) send(frame1[i], 1'b0);
        check("s5_busy_pre", 32'(busy), 32'd1);
        rst_f    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h77;
        tick();
        rst_f    = 1'b0;
        in_valid = 1'b0;
        check("s5_rst_ready", 32'(in_ready), 32'd0);
        check("s5_rst_core", 32'(core_rst_f), 32'd0);
        check("s5_rst_addr", 32'(im_addr), 32'd0);
        check("s5_rst_wdata", im_wdata, 32'd0);
        check("s5_rst_flags", {28'd0, im_we, busy, done, err}, 32'd0);
        wa.delete();
        wd.delete();
        tick();
        check("s5_ready", 32'(in_ready), 32'd1);
        send_frame(frame_dead, 1'b0);
        tick();
        check_writes("s5", 1, 32'hDEADBEEF, 32'h0);
        check("s5_done", 32'(done), 32'd1);

        // Scenario 6: in_valid toggling every cycle.
        do_reset();
        send_frame(frame1, 1'b1);
        tick();
        check_writes("s6", 2, 32'h11223344, 32'h55667788);
        check("s6_done", 32'(done), 32'd1);
        check("s6_core", 32'(core_rst_f), 32'd1);
        check("s6_err", 32'(err), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
